// File: rtl/risc_mc_control.sv
// risc_mc_control: multicycle fetch/decode/exec/mem/wb control FSM with retired-instruction counter
module risc_mc_control #(
  parameter int OPW   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic [1:0]       M2,
  output logic [1:0]       wb_src,
  output logic             reg_write,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  localparam logic [OPW-1:0] OP_R    = OPW'(0);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
  localparam logic [OPW-1:0] OP_LW   = OPW'(2);
  localparam logic [OPW-1:0] OP_SW   = OPW'(3);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(4);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(5);
  localparam logic [OPW-1:0] OP_J    = OPW'(6);
  localparam logic [OPW-1:0] OP_HALT = OPW'(15);
  state_t state, nxt;
  logic [OPW-1:0] op_q;
  logic [CNT_W-1:0] cnt;
  logic taken;
  assign taken = (op_q == OP_BEQ) && zero;
  assign instr_count = rst ? '0 : cnt;
  always_comb begin
    nxt = state;
    mem_req = 1'b0;
    mem_we = 1'b0;
    iord = 1'b0;
    ir_load = 1'b0;
    pc_write = 1'b0;
    pc_src = 2'b00;
    alu_src = 1'b0;
    alu_op = 2'b00;
    M2 = 2'b01;
    wb_src = 2'b00;
    reg_write = 1'b0;
    halted = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
        pc_write = mem_ready;
        nxt = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        pc_write = opcode == OP_J;
        pc_src = opcode == OP_J ? 2'b10 : 2'b00;
        nxt = opcode == OP_J ? FETCH :
              opcode == OP_JAL ? WB :
              opcode == OP_HALT ? HALT :
              opcode inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ} ? EXEC : FETCH;
      end
      EXEC: begin
        alu_src = op_q inside {OP_ADDI, OP_LW, OP_SW};
        alu_op = op_q == OP_R ? 2'b10 : op_q == OP_BEQ ? 2'b01 : 2'b00;
        pc_write = taken;
        pc_src = taken ? 2'b01 : 2'b00;
        nxt = op_q inside {OP_R, OP_ADDI} ? WB : op_q inside {OP_LW, OP_SW} ? MEM : FETCH;
      end
      MEM: begin
        mem_req = 1'b1;
        iord = 1'b1;
        mem_we = op_q == OP_SW;
        nxt = !mem_ready ? MEM : op_q == OP_LW ? WB : FETCH;
      end
      WB: begin
        reg_write = 1'b1;
        M2 = op_q == OP_R ? 2'b10 : op_q == OP_JAL ? 2'b00 : 2'b01;
        wb_src = op_q == OP_LW ? 2'b01 : op_q == OP_JAL ? 2'b10 : 2'b00;
        pc_write = op_q == OP_JAL;
        pc_src = op_q == OP_JAL ? 2'b10 : 2'b00;
        nxt = FETCH;
      end
      HALT: halted = 1'b1;
      default: nxt = FETCH;
    endcase
    if (rst) begin
      mem_req = 1'b0;
      mem_we = 1'b0;
      iord = 1'b0;
      ir_load = 1'b0;
      pc_write = 1'b0;
      pc_src = 2'b00;
      alu_src = 1'b0;
      alu_op = 2'b00;
      M2 = 2'b01;
      wb_src = 2'b00;
      reg_write = 1'b0;
      halted = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      op_q <= '0;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (state == DECODE) op_q <= opcode;
      if (nxt == FETCH && state != FETCH) cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_risc_mc_control.sv
// tb_risc_mc_control: randomized instruction-level check of the multicycle control FSM
module tb_risc_mc_control;
  localparam int CW = 4;
  localparam logic [3:0] R = 0, ADDI = 1, LW = 2, SW = 3, BEQ = 4, JAL = 5, J = 6, HLT_OP = 15;
  localparam logic [15:0] MREQ = 16'h8000, WE = 16'h4000, IORD = 16'h2000, IRL = 16'h1000;
  localparam logic [15:0] PCW = 16'h0800, PCS_J = 16'h0400, PCS_BR = 16'h0200, ALUS = 16'h0100;
  localparam logic [15:0] AOP_F = 16'h0080, AOP_SUB = 16'h0040, M2_RD = 16'h0020, M2_RT = 16'h0010;
  localparam logic [15:0] M2_LINK = 16'h0000, WB_PC = 16'h0008, WB_MEM = 16'h0004, RW = 16'h0002, HLT = 16'h0001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] opcode = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b1;
  logic mem_req, mem_we, iord, ir_load, pc_write, alu_src, reg_write, halted;
  logic [1:0] pc_src, alu_op, M2, wb_src;
  logic [CW-1:0] instr_count;
  logic [15:0] obs;
  int total = 0;
  int bad = 0;
  int cnt_m = 0;
  risc_mc_control #(.OPW(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_load(ir_load), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op), .M2(M2), .wb_src(wb_src),
    .reg_write(reg_write), .halted(halted), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  assign obs = {mem_req, mem_we, iord, ir_load, pc_write, pc_src, alu_src, alu_op, M2, wb_src, reg_write, halted};
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic [15:0] e, input logic mr, input logic z);
    mem_ready = mr;
    zero = z;
    @(negedge clk);
    chk({tag, "_ctl"}, 32'(obs), 32'(e));
    chk({tag, "_cnt"}, 32'(instr_count), 32'(cnt_m));
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    cnt_m = 0;
    for (int i = 0; i < n; i++) step("rst", M2_RT, 1'b1, rb());
    rst = 1'b0;
  endtask
  task automatic do_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
    opcode = 4'($urandom);
    for (int i = 0; i < fw; i++) step("fetch_wait", MREQ | M2_RT, 1'b0, rb());
    step("fetch", MREQ | IRL | PCW | M2_RT, 1'b1, rb());
    opcode = op;
    step("decode", op == J ? (PCW | PCS_J | M2_RT) : M2_RT, rb(), rb());
    case (op)
      R: begin
        step("exec_r", AOP_F | M2_RT, rb(), rb());
        step("wb_r", RW | M2_RD, rb(), rb());
      end
      ADDI: begin
        step("exec_addi", ALUS | M2_RT, rb(), rb());
        step("wb_addi", RW | M2_RT, rb(), rb());
      end
      LW: begin
        step("exec_lw", ALUS | M2_RT, rb(), rb());
        for (int i = 0; i < mw; i++) step("mem_lw_wait", MREQ | IORD | M2_RT, 1'b0, rb());
        step("mem_lw", MREQ | IORD | M2_RT, 1'b1, rb());
        step("wb_lw", RW | M2_RT | WB_MEM, rb(), rb());
      end
      SW: begin
        step("exec_sw", ALUS | M2_RT, rb(), rb());
        for (int i = 0; i < mw; i++) step("mem_sw_wait", MREQ | WE | IORD | M2_RT, 1'b0, rb());
        step("mem_sw", MREQ | WE | IORD | M2_RT, 1'b1, rb());
      end
      BEQ: step("exec_beq", AOP_SUB | M2_RT | (z ? (PCW | PCS_BR) : 16'h0), rb(), z);
      JAL: step("wb_jal", RW | M2_LINK | WB_PC | PCW | PCS_J, rb(), rb());
      HLT_OP: for (int i = 0; i < 10; i++) step("halt", HLT | M2_RT, rb(), rb());
      default: ;
    endcase
    if (op != HLT_OP) cnt_m = (cnt_m + 1) % (1 << CW);
  endtask
  initial begin
    do_reset(2);
    do_instr(R, 1'b0, 0, 0);
    do_instr(LW, 1'b0, 0, 3);
    do_instr(JAL, 1'b0, 0, 0);
    do_instr(BEQ, 1'b1, 0, 0);
    do_instr(BEQ, 1'b0, 1, 0);
    for (int k = 0; k < 40; k++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      do_instr(op, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    opcode = 4'($urandom);
    step("fetch_wait", MREQ | M2_RT, 1'b0, rb());
    do_reset(1);
    do_instr(SW, 1'b0, 0, 1);
    do_instr(4'b1010, 1'b0, 0, 0);
    do_instr(HLT_OP, 1'b0, 0, 0);
    do_reset(2);
    for (int k = 0; k < 17; k++) do_instr(J, 1'b0, 0, 0);
    @(negedge clk);
    chk("wrap", 32'(instr_count), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
